// File: rtl/sat_engine_pkg.sv
// Shared types and encodings for the SAT engine clause-array cells.
package sat_engine_pkg;

  localparam int unsigned DefWidthLvl = 16;

  typedef enum logic [2:0] {
    StIdle,
    StEval,
    StImply,
    StConflict,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    StatusNone     = 2'b00,
    StatusImplied  = 2'b01,
    StatusConflict = 2'b10,
    StatusSat      = 2'b11
  } status_e;

  localparam logic [1:0] FreeNone = 2'b00;
  localparam logic [1:0] FreeOne  = 2'b01;
  localparam logic [1:0] FreeMany = 2'b11;

endpackage

// File: rtl/clause_terminal.sv
// Row terminal cell: classifies a clause on request and pulses the implication
// or conflict drive back into the row's literal cells.
module clause_terminal
  import sat_engine_pkg::*;
#(
  parameter int unsigned WIDTH_LVL = DefWidthLvl
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [1:0]           freelitcnt_i,
  input  logic                 clausesat_i,
  input  logic                 cclause_i,
  input  logic [WIDTH_LVL-1:0] max_lvl_i,
  input  logic                 start_i,
  input  logic                 clear_i,
  output logic                 imp_drv_o,
  output logic                 cclause_drv_o,
  output logic [WIDTH_LVL-1:0] max_lvl_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           status_o,
  output logic                 implied_o
);

  state_e               state_q;
  logic                 snap_valid_q;
  logic [1:0]           snap_free_q;
  logic                 snap_sat_q;
  logic                 snap_cclause_q;
  logic [WIDTH_LVL-1:0] lvl_q;
  logic                 imp_drv_q;
  logic                 cclause_drv_q;
  logic                 done_q;
  logic [1:0]           status_q;
  logic                 implied_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      snap_valid_q   <= 1'b0;
      snap_free_q    <= FreeNone;
      snap_sat_q     <= 1'b0;
      snap_cclause_q <= 1'b0;
      lvl_q          <= '0;
      imp_drv_q      <= 1'b0;
      cclause_drv_q  <= 1'b0;
      done_q         <= 1'b0;
      status_q       <= StatusNone;
      implied_q      <= 1'b0;
    end else begin
      // Drives and done are single-cycle pulses unless re-asserted below.
      imp_drv_q     <= 1'b0;
      cclause_drv_q <= 1'b0;
      done_q        <= 1'b0;
      if (clear_i) begin
        state_q   <= StIdle;
        implied_q <= 1'b0;
        status_q  <= StatusNone;
        lvl_q     <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_i) begin
              state_q        <= StEval;
              snap_valid_q   <= valid_i;
              snap_free_q    <= freelitcnt_i;
              snap_sat_q     <= clausesat_i;
              snap_cclause_q <= cclause_i;
              lvl_q          <= max_lvl_i;
              status_q       <= StatusNone;
            end
          end
          StEval: begin
            if (!snap_valid_q) begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              status_q <= StatusNone;
            end else if (snap_cclause_q) begin
              state_q       <= StConflict;
              cclause_drv_q <= 1'b1;
            end else if (snap_sat_q) begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              status_q <= StatusSat;
            end else if (snap_free_q == FreeNone) begin
              state_q       <= StConflict;
              cclause_drv_q <= 1'b1;
            end else if (snap_free_q == FreeOne && !implied_q) begin
              state_q   <= StImply;
              imp_drv_q <= 1'b1;
            end else begin
              // Two or more free literals, or the unit rule already fired.
              state_q  <= StDone;
              done_q   <= 1'b1;
              status_q <= StatusNone;
            end
          end
          StImply: begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            status_q  <= StatusImplied;
            implied_q <= 1'b1;
          end
          StConflict: begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            status_q <= StatusConflict;
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign imp_drv_o     = imp_drv_q;
  assign cclause_drv_o = cclause_drv_q;
  assign max_lvl_o     = lvl_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign status_o      = status_q;
  assign implied_o     = implied_q;

endmodule

// File: tb/tb_clause_terminal.sv
// Directed bench for clause_terminal with hand-computed expectations.
module tb_clause_terminal;

  localparam int unsigned WIDTH_LVL = 16;

  logic                 clk;
  logic                 rst;
  logic                 valid_i;
  logic [1:0]           freelitcnt_i;
  logic                 clausesat_i;
  logic                 cclause_i;
  logic [WIDTH_LVL-1:0] max_lvl_i;
  logic                 start_i;
  logic                 clear_i;
  logic                 imp_drv_o;
  logic                 cclause_drv_o;
  logic [WIDTH_LVL-1:0] max_lvl_o;
  logic                 busy_o;
  logic                 done_o;
  logic [1:0]           status_o;
  logic                 implied_o;

  int passed = 0;
  int total  = 0;

  clause_terminal #(.WIDTH_LVL(WIDTH_LVL)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .freelitcnt_i (freelitcnt_i),
    .clausesat_i  (clausesat_i),
    .cclause_i    (cclause_i),
    .max_lvl_i    (max_lvl_i),
    .start_i      (start_i),
    .clear_i      (clear_i),
    .imp_drv_o    (imp_drv_o),
    .cclause_drv_o(cclause_drv_o),
    .max_lvl_o    (max_lvl_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .status_o     (status_o),
    .implied_o    (implied_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents row inputs with start high for one edge; returns #1 after that edge.
  task automatic start_row(input logic v, input logic [1:0] f, input logic s,
                           input logic c, input logic [WIDTH_LVL-1:0] l);
    valid_i      = v;
    freelitcnt_i = f;
    clausesat_i  = s;
    cclause_i    = c;
    max_lvl_i    = l;
    start_i      = 1'b1;
    tick();
    start_i      = 1'b0;
  endtask

  // {imp_drv, cclause_drv, busy, done, status, implied}
  function automatic logic [31:0] flags();
    return {25'd0, imp_drv_o, cclause_drv_o, busy_o, done_o, status_o, implied_o};
  endfunction

  initial begin
    rst = 1'b0; valid_i = 1'b0; freelitcnt_i = 2'b00; clausesat_i = 1'b0;
    cclause_i = 1'b0; max_lvl_i = '0; start_i = 1'b0; clear_i = 1'b0;
    #22;
    chk("reset_flags", flags(), 32'h0);
    chk("reset_lvl", 32'(max_lvl_o), 32'h0);
    rst = 1'b1;
    tick();

    // Unit clause
    start_row(1'b1, 2'b01, 1'b0, 1'b0, 16'd5);
    chk("unit_eval_busy", flags(), 32'b0010_00_0);
    tick();
    chk("unit_imply_flags", flags(), 32'b1010_00_0);
    chk("unit_imply_lvl", 32'(max_lvl_o), 32'd5);
    tick();
    chk("unit_done_flags", flags(), 32'b0011_01_1);
    tick();
    chk("unit_idle_hold", flags(), 32'b0000_01_1);

    // Repeat without clear: unit rule must not fire again
    start_row(1'b1, 2'b01, 1'b0, 1'b0, 16'd5);
    tick();
    chk("repeat_done_flags", flags(), 32'b0011_00_1);
    tick();

    // Clear then repeat: implies again
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clear_flags", flags(), 32'h0);
    chk("clear_lvl", 32'(max_lvl_o), 32'h0);
    start_row(1'b1, 2'b01, 1'b0, 1'b0, 16'd5);
    tick();
    chk("reimply_flags", flags(), 32'b1010_00_0);
    tick();
    chk("reimply_done", flags(), 32'b0011_01_1);
    tick();

    // All-false clause
    start_row(1'b1, 2'b00, 1'b0, 1'b0, 16'd9);
    tick();
    chk("allfalse_conf_flags", flags(), 32'b0110_00_1);
    chk("allfalse_lvl", 32'(max_lvl_o), 32'd9);
    tick();
    chk("allfalse_done", flags(), 32'b0011_10_1);
    tick();

    // Priority: cclause beats clausesat
    start_row(1'b1, 2'b01, 1'b1, 1'b1, 16'd3);
    tick();
    chk("prio_conf_flags", flags(), 32'b0110_00_1);
    tick();
    chk("prio_conf_done", flags(), 32'b0011_10_1);
    tick();
    // Satisfied beats unit
    start_row(1'b1, 2'b01, 1'b1, 1'b0, 16'd4);
    tick();
    chk("sat_done", flags(), 32'b0011_11_1);
    tick();
    // Empty row
    start_row(1'b0, 2'b01, 1'b0, 1'b0, 16'd7);
    tick();
    chk("empty_done", flags(), 32'b0011_00_1);
    tick();
    // Two or more free literals with implied state cleared
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    start_row(1'b1, 2'b11, 1'b0, 1'b0, 16'd8);
    tick();
    chk("many_done", flags(), 32'b0011_00_0);
    tick();

    // Abort: start in busy cycle ignored, clear in IMPLY cycle
    start_row(1'b1, 2'b01, 1'b0, 1'b0, 16'd6);
    max_lvl_i = 16'd12;
    start_i   = 1'b1;
    tick();
    start_i = 1'b0;
    chk("abort_imply_flags", flags(), 32'b1010_00_0);
    chk("busy_start_ignored_lvl", 32'(max_lvl_o), 32'd6);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("abort_flags", flags(), 32'h0);
    chk("abort_lvl", 32'(max_lvl_o), 32'h0);
    tick();
    chk("abort_no_done", flags(), 32'h0);

    // Clear and start together: start dropped
    clear_i = 1'b1;
    start_i = 1'b1;
    tick();
    clear_i = 1'b0;
    start_i = 1'b0;
    chk("clear_start_idle", flags(), 32'h0);
    tick();
    chk("clear_start_still_idle", flags(), 32'h0);

    // Async reset in the CONFLICT cycle
    start_row(1'b1, 2'b00, 1'b0, 1'b0, 16'd9);
    tick();
    chk("areset_pre_conf", flags(), 32'b0110_00_0);
    #3;
    rst = 1'b0;
    #1;
    chk("areset_drive_drop", flags(), 32'h0);
    chk("areset_lvl", 32'(max_lvl_o), 32'h0);
    #2;
    rst = 1'b1;
    tick();
    chk("areset_after_flags", flags(), 32'h0);
    chk("areset_after_lvl", 32'(max_lvl_o), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clause_terminal.md
Name: clause_terminal

Overview:
- Per-row terminal cell at the right end of a clause-array row, directly downstream of the row's literal cells.
- Consumes the row's free-literal count chain, satisfied/conflict flags and maximum assigned level.
- Under a start/done handshake with the BCP controller, classifies the clause as satisfied, unit, conflicting or idle.
- Pulses the row-wide implication drive or conflict drive back into the literal cells.

Parameters:
- WIDTH_LVL, 16, width of decision-level values.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- valid_i  input  1  row holds a loaded clause; 0 means the row is empty.
- freelitcnt_i  input  2  free-literal count from the last literal cell: 00 none, 01 one, 11 two or more.
- clausesat_i  input  1  OR of the row's literal clausesat outputs.
- cclause_i  input  1  OR of the row's literal cclause outputs (an implied variable was contradicted).
- max_lvl_i  input  WIDTH_LVL  maximum level of the row's assigned literals (row reduction).
- start_i  input  1  one-cycle request to evaluate the row.
- clear_i  input  1  backtrack: clear the implied state and abort any operation.
- imp_drv_o  output  1  implication drive to all literal cells.
- cclause_drv_o  output  1  conflict drive to all literal cells.
- max_lvl_o  output  WIDTH_LVL  level captured at evaluation; given to literal cells as the implied level.
- busy_o  output  1  FSM not in IDLE.
- done_o  output  1  one-cycle completion pulse.
- status_o  output  2  00 none, 01 implied, 10 conflict, 11 satisfied; held until the next start or clear.
- implied_o  output  1  this clause has produced an implication since the last clear.

Behaviour:
- Reset (async, rst=0): state IDLE. All outputs 0, max_lvl_o=0. Internal registers cleared.
- States: IDLE, EVAL, IMPLY, CONFLICT, DONE. All outputs are registered or decoded from registered state only.
- IDLE:
  - start_i=1 → EVAL.
  - On the same edge, capture valid_i, freelitcnt_i, clausesat_i, cclause_i and max_lvl_i into snapshot registers.
- EVAL: decide from the snapshot in strict priority order:
  - valid=0 → DONE, status 00.
  - cclause=1 → CONFLICT.
  - clausesat=1 → DONE, status 11.
  - freelitcnt=00 → CONFLICT (all literals false).
  - freelitcnt=01 and implied_o=0 → IMPLY.
  - Otherwise (freelitcnt=11, or already implied) → DONE, status 00.
- IMPLY:
  - imp_drv_o=1 for exactly this cycle; max_lvl_o = snapshot level.
  - implied_o set on exit.
  - → DONE, status 01.
- CONFLICT:
  - cclause_drv_o=1 for exactly this cycle; max_lvl_o = snapshot level.
  - → DONE, status 10.
- DONE: done_o=1 for one cycle → IDLE.
- max_lvl_o:
  - Holds the last captured level until the next capture.
  - Cleared to 0 by clear_i.
- Latency (start sampled at edge N):
  - done_o high in cycle N+2 when no drive is issued.
  - done_o high in cycle N+3 for IMPLY or CONFLICT.
- start_i while busy_o=1 is ignored; no queueing.
- clear_i (synchronous, highest priority over all transitions):
  - state → IDLE; implied_o, status_o, max_lvl_o → 0.
  - Drives deassert next cycle; no done_o pulse for the aborted operation.
  - clear_i and start_i together: clear wins and start is dropped.
- implied_o stays set across further starts until clear_i or reset, so the unit rule fires at most once per row between backtracks.
- Level values are unsigned and carried unchanged; no arithmetic on levels.
- Reset asserted mid-operation: immediate return to the reset state, with drives low asynchronously.

Decomposition:
- Shared sat_engine package holds:
  - FSM state enum.
  - status codes NONE/IMPLIED/CONFLICT/SAT.
  - freelitcnt encodings FREE_NONE=00, FREE_ONE=01, FREE_MANY=11.
  - Default WIDTH_LVL.
- No sub-module is needed. The row max-level reduction stays in the row wrapper, outside this block.

Test Plan:
- Unit clause: valid=1, freelitcnt=01, sat=0, max_lvl=5, start at N → imp_drv_o=1 in N+2 with max_lvl_o=5; done_o in N+3 with status=01; implied_o=1.
- Repeat start with the same inputs and no clear → no imp_drv_o; done at N+2 with status=00. After clear_i, a repeated start implies again.
- All-false clause: freelitcnt=00, sat=0, max_lvl=9 → cclause_drv_o=1 in N+2 with max_lvl_o=9; done N+3 with status=10.
- Priority: cclause_i=1 with clausesat_i=1 → CONFLICT. Next start with sat=1, freelitcnt=01 → status=11, no drive. valid=0 → status=00 at N+2.
- Abort: clear_i asserted in the IMPLY cycle → next cycle IDLE, no done_o, status=00, implied_o=0. A start_i raised in the busy cycle is ignored.
- Async reset: rst low in the CONFLICT cycle, away from a clock edge → cclause_drv_o drops immediately; all outputs 0 after release.
